// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BCD_W    = 4;
    localparam int N_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble pre-shift correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] dig_i,
    output logic [BCD_W-1:0] dig_o
);

    // Add-3 correction so the following shift carries into the next digit correctly
    always_comb begin
        dig_o = dig_i;
        if (dig_i >= 4'd5) begin
            dig_o = dig_i + 4'd3;
        end else begin
            dig_o = dig_i;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, valid/ready on both sides,
// result digits held in dedicated output flops so partial values never appear.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       bcd_uni,
    output logic [3:0]       bcd_dec,
    output logic [3:0]       bcd_cen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int DIG_W = N_DIGITS * BCD_W;
    localparam int SH_W  = DIG_W + BIN_W;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [DIG_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DIG_W-1:0] dig_adj_s;
    logic [SH_W-1:0]  shift_s;
    logic             unused_s;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (dig_q[g*BCD_W +: BCD_W]),
            .dig_o (dig_adj_s[g*BCD_W +: BCD_W])
        );
    end

    // The hundreds digit never reaches 8 for BIN_W <= 9, so its top bit is shifted out
    assign shift_s  = {dig_adj_s[DIG_W-2:0], bin_q, 1'b0};
    assign unused_s = dig_adj_s[DIG_W-1];

    // Next-state and datapath control for IDLE -> CONV -> DONE
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        dig_d       = dig_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    dig_d   = {DIG_W{1'b0}};
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                bin_d = shift_s[BIN_W-1:0];
                dig_d = shift_s[SH_W-1:BIN_W];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d       = shift_s[SH_W-1:BIN_W];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_CONV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, working registers and result registers; reset aborts any conversion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bin_q       <= {BIN_W{1'b0}};
            dig_q       <= {DIG_W{1'b0}};
            res_q       <= {DIG_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            dig_q       <= dig_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bcd_uni   = res_q[0*BCD_W +: BCD_W];
    assign bcd_dec   = res_q[1*BCD_W +: BCD_W];
    assign bcd_cen   = res_q[2*BCD_W +: BCD_W];
    assign out_valid = out_valid_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq with BIN_W = 8.
module tb_bin_to_bcd_seq;

    logic       clk;
    logic       rst;
    logic [7:0] bin_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd_uni;
    logic [3:0] bcd_dec;
    logic [3:0] bcd_cen;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int total;
    int bad;

    bin_to_bcd_seq #(.BIN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_uni   (bcd_uni),
        .bcd_dec   (bcd_dec),
        .bcd_cen   (bcd_cen),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] bcd_of(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Full transfer from IDLE with immediate consumer acceptance; exp is BCD as a hex literal
    task automatic do_conv(input logic [7:0] v, input logic [11:0] exp);
        bin_in   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("busy_conv", {31'd0, busy}, 32'd1);
        chk("ready_conv", {31'd0, in_ready}, 32'd0);
        repeat (7) step();
        chk("early_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("valid_at_lat", {31'd0, out_valid}, 32'd1);
        chk("digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, {20'd0, exp});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("valid_cleared", {31'd0, out_valid}, 32'd0);
        chk("ready_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        bin_in    = 8'd77;
        out_ready = 1'b0;

        // reset state, transfer requests discarded
        repeat (3) step();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        do_conv(8'd0,   12'h000);
        do_conv(8'd255, 12'h255);
        do_conv(8'd99,  12'h099);
        do_conv(8'd100, 12'h100);

        // 137 held while consumer stalls
        bin_in   = 8'd137;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        chk("hold_valid0", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'h137);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bin_in    = 8'd3;
        step();
        chk("hs_valid", {31'd0, out_valid}, 32'd0);
        chk("hs_no_accept", {31'd0, busy}, 32'd0);
        chk("hs_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'h137);
        out_ready = 1'b0;
        step();
        chk("next_accept", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        repeat (7) step();
        chk("conv_keeps_old", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'h137);
        chk("conv3_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("conv3_valid", {31'd0, out_valid}, 32'd1);
        chk("conv3_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'h003);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // 42 pulsed during CONV and DONE of 200 must be ignored
        bin_in   = 8'd200;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        bin_in   = 8'd42;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        bin_in   = 8'd0;
        repeat (4) step();
        chk("ign_early", {31'd0, out_valid}, 32'd0);
        step();
        chk("ign_valid", {31'd0, out_valid}, 32'd1);
        chk("ign_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'h200);
        bin_in   = 8'd42;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ign_done_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'h200);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (2) step();
        chk("ign_no_queue_busy", {31'd0, busy}, 32'd0);
        chk("ign_no_queue_valid", {31'd0, out_valid}, 32'd0);

        // reset in the middle of a conversion clears the previous result
        do_conv(8'd123, 12'h123);
        bin_in   = 8'd255;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, 32'd0);
        in_valid = 1'b1;
        bin_in   = 8'd9;
        step();
        chk("abort_discard", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        do_conv(8'd7, 12'h007);

        // exhaustive back-to-back sweep, one result every 10 cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int v = 0; v < 256; v++) begin
            bin_in = v[7:0];
            step();
            chk("sw_busy", {31'd0, busy}, 32'd1);
            repeat (7) step();
            chk("sw_early", {31'd0, out_valid}, 32'd0);
            step();
            chk("sw_valid", {31'd0, out_valid}, 32'd1);
            chk("sw_digits", {20'd0, bcd_cen, bcd_dec, bcd_uni}, {20'd0, bcd_of(v)});
            step();
            chk("sw_idle", {31'd0, in_ready}, 32'd1);
            chk("sw_cleared", {31'd0, out_valid}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
